// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Multi-cycle FSM controller of the simple CPU. It fetches a 16-bit
// instruction from RAM over a request/ack handshake and latches it in the
// instruction register (IR). It then decodes the instruction and sequences
// the ALU, the register-file write enables and the PC update.
//
// Instruction format: op=IR[15:13], IR[12]=imm flag, IR[11:10]=dest,
//                     IR[9:8]=src, IR[7:0]=imm/target
// Opcodes: 000 MOV, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 JMP, 110/111 NOP
//
// Ports:
//   clk         in   1   clock, rising edge
//   rst         in   1   synchronous, active-low reset
//   alu_end     in   1   ALU done pulse, sampled only in EXEC
//   ins         in   16  instruction word from RAM
//   en_ram_out  in   1   RAM ack (ins valid), sampled only in FETCH
//   en_ram_in   out  1   RAM read request, high throughout FETCH
//   en_group    out  1   ALU/register-group enable, high throughout EXEC
//   en_pc       out  1   PC update strobe (PCUPD)
//   reg_en      out  4   one-hot register write enable (WB)
//   alu_in_sel  out  1   ALU operand B: 0 = register, 1 = immediate
//   alu_func    out  3   000 pass, 001 add, 010 sub, 011 and, 100 or
//   pc_ctrl     out  2   00 hold, 01 increment, 10 load IR[7:0]
//   ir_out      out  16  IR contents
//
// Configuration macro: CU_ILLEGAL_HALT_EN
//   defined   : op 110/111 enter HALT (all outputs 0, ir_out holds IR) until reset
//   undefined : op 110/111 execute as NOP (PC increment, no register write)
// -----------------------------------------------------------------------------
module control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_end,
  input  logic [15:0] ins,
  input  logic        en_ram_out,
  output logic        en_ram_in,
  output logic        en_group,
  output logic        en_pc,
  output logic [3:0]  reg_en,
  output logic        alu_in_sel,
  output logic [2:0]  alu_func,
  output logic [1:0]  pc_ctrl,
  output logic [15:0] ir_out
);

  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_JMP = 3'b101;

  localparam logic [2:0] FUNC_PASS = 3'b000;
  localparam logic [2:0] FUNC_ADD  = 3'b001;
  localparam logic [2:0] FUNC_SUB  = 3'b010;
  localparam logic [2:0] FUNC_AND  = 3'b011;
  localparam logic [2:0] FUNC_OR   = 3'b100;

  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_JUMP = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
`ifdef CU_ILLEGAL_HALT_EN
    S_PCUPD  = 3'd5,
    S_HALT   = 3'd6
`else
    S_PCUPD  = 3'd5
`endif
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_ir;

  logic [2:0]  w_op;
  logic        w_is_exec;
  logic        w_is_jmp;

  assign w_op      = r_ir[15:13];
  // MOV and the four ALU ops are exactly the opcodes 000..100.
  assign w_is_exec = (w_op <= OP_OR);
  assign w_is_jmp  = (w_op == OP_JMP);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      // NOTE: IR is reset along with the state because ir_out is visible
      // and must read 0 after reset, not whatever was last fetched.
      r_ir    <= '0;
    end else begin
      r_state <= w_state_next;
      // IR only captures on a FETCH ack, so it is stable until the next one.
      if (r_state == S_FETCH && en_ram_out) begin
        r_ir <= ins;
      end
    end
  end

  // Next-state and Moore output decode (state and IR only).
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would infer a latch.
    w_state_next = r_state;
    en_ram_in    = 1'b0;
    en_group     = 1'b0;
    en_pc        = 1'b0;
    reg_en       = 4'b0000;
    alu_in_sel   = 1'b0;
    alu_func     = FUNC_PASS;
    pc_ctrl      = 2'b00;

    case (r_state)
      S_IDLE: w_state_next = S_FETCH;

      S_FETCH: begin
        en_ram_in = 1'b1;
        if (en_ram_out) begin
          w_state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        if (w_is_exec) begin
          w_state_next = S_EXEC;
        end else if (w_is_jmp) begin
          w_state_next = S_PCUPD;
        end else begin
`ifdef CU_ILLEGAL_HALT_EN
          w_state_next = S_HALT;
`else
          w_state_next = S_PCUPD;
`endif
        end
      end

      S_EXEC: begin
        en_group = 1'b1;
        case (w_op)
          OP_ADD:  alu_func = FUNC_ADD;
          OP_SUB:  alu_func = FUNC_SUB;
          OP_AND:  alu_func = FUNC_AND;
          OP_OR:   alu_func = FUNC_OR;
          default: alu_func = FUNC_PASS;
        endcase
        // MOV always moves the immediate; ALU ops choose by the imm flag.
        alu_in_sel = (w_op == OP_MOV) ? 1'b1 : r_ir[12];
        if (alu_end) begin
          w_state_next = S_WB;
        end
      end

      S_WB: begin
        reg_en       = 4'b0001 << r_ir[11:10];
        w_state_next = S_PCUPD;
      end

      S_PCUPD: begin
        en_pc        = 1'b1;
        pc_ctrl      = w_is_jmp ? PC_JUMP : PC_INC;
        w_state_next = S_FETCH;
      end

`ifdef CU_ILLEGAL_HALT_EN
      S_HALT: w_state_next = S_HALT;
`endif

      default: w_state_next = S_IDLE;
    endcase
  end

  assign ir_out = r_ir;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//
// Directed bench for control_unit. Each step drives inputs, pushes the
// expected output vector for the following cycle to a scoreboard queue,
// and pops/compares it against the DUT on the next falling edge.
// -----------------------------------------------------------------------------
module tb_control_unit;

  typedef struct packed {
    logic        en_ram_in;
    logic        en_group;
    logic        en_pc;
    logic [3:0]  reg_en;
    logic        alu_in_sel;
    logic [2:0]  alu_func;
    logic [1:0]  pc_ctrl;
    logic [15:0] ir_out;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        alu_end;
  logic [15:0] ins;
  logic        en_ram_out;
  logic        en_ram_in;
  logic        en_group;
  logic        en_pc;
  logic [3:0]  reg_en;
  logic        alu_in_sel;
  logic [2:0]  alu_func;
  logic [1:0]  pc_ctrl;
  logic [15:0] ir_out;

  exp_t  w_obs;
  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .alu_end    (alu_end),
    .ins        (ins),
    .en_ram_out (en_ram_out),
    .en_ram_in  (en_ram_in),
    .en_group   (en_group),
    .en_pc      (en_pc),
    .reg_en     (reg_en),
    .alu_in_sel (alu_in_sel),
    .alu_func   (alu_func),
    .pc_ctrl    (pc_ctrl),
    .ir_out     (ir_out)
  );

  assign w_obs = {en_ram_in, en_group, en_pc, reg_en, alu_in_sel, alu_func, pc_ctrl, ir_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t o_zero(input logic [15:0] ir);
    exp_t e = '0;
    e.ir_out = ir;
    return e;
  endfunction

  function automatic exp_t o_fetch(input logic [15:0] ir);
    exp_t e = o_zero(ir);
    e.en_ram_in = 1'b1;
    return e;
  endfunction

  function automatic exp_t o_exec(input logic [15:0] ir, input logic [2:0] func, input logic sel);
    exp_t e = o_zero(ir);
    e.en_group   = 1'b1;
    e.alu_func   = func;
    e.alu_in_sel = sel;
    return e;
  endfunction

  function automatic exp_t o_wb(input logic [15:0] ir, input logic [3:0] re);
    exp_t e = o_zero(ir);
    e.reg_en = re;
    return e;
  endfunction

  function automatic exp_t o_pc(input logic [15:0] ir, input logic [1:0] ctrl);
    exp_t e = o_zero(ir);
    e.en_pc   = 1'b1;
    e.pc_ctrl = ctrl;
    return e;
  endfunction

  // Inputs are already driven; push the expectation, run one clock, compare.
  task automatic tick(input string tag, input exp_t e);
    exp_t  x;
    string t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    x = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (w_obs === x) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, w_obs, x);
    end
  endtask

  // From FETCH: ack ins, run MOV/ALU op through EXEC/WB/PCUPD back to FETCH.
  task automatic run_alu(input string tag, input logic [15:0] word, input logic [2:0] func,
                         input logic sel, input logic [3:0] re, input int wait_cycles);
    ins = word; en_ram_out = 1'b1;
    tick({tag, "_decode"}, o_zero(word));
    // IR must ignore ins and acks outside FETCH.
    ins = ~word; en_ram_out = 1'b1;
    tick({tag, "_exec0"}, o_exec(word, func, sel));
    en_ram_out = 1'b0;
    for (int i = 0; i < wait_cycles; i++) tick({tag, "_exec_wait"}, o_exec(word, func, sel));
    alu_end = 1'b1;
    tick({tag, "_wb"}, o_wb(word, re));
    alu_end = 1'b0;
    tick({tag, "_pcupd"}, o_pc(word, 2'b01));
    tick({tag, "_fetch"}, o_fetch(word));
  endtask

  initial begin
    rst = 1'b0; alu_end = 1'b0; ins = 16'h0000; en_ram_out = 1'b0;

    // Reset held 3 cycles.
    for (int i = 0; i < 3; i++) tick("reset", o_zero(16'h0000));
    rst = 1'b1;
    tick("fetch_after_reset", o_fetch(16'h0000));

    // No ack: FETCH holds; stray alu_end and changing ins are ignored.
    alu_end = 1'b1; ins = 16'h1234;
    tick("fetch_wait", o_fetch(16'h0000));
    alu_end = 1'b0;

    run_alu("mov",  16'h0002, 3'b000, 1'b1, 4'b0001, 0);
    run_alu("sub",  16'h5404, 3'b010, 1'b1, 4'b0010, 4);
    run_alu("or",   16'h9C02, 3'b100, 1'b1, 4'b1000, 0);
    run_alu("and",  16'h7802, 3'b011, 1'b1, 4'b0100, 1);
    run_alu("add",  16'h2500, 3'b001, 1'b0, 4'b0010, 0);

    // JMP: DECODE -> PCUPD (load) -> FETCH.
    ins = 16'hA001; en_ram_out = 1'b1;
    tick("jmp_decode", o_zero(16'hA001));
    en_ram_out = 1'b0; alu_end = 1'b1;
    tick("jmp_pcupd", o_pc(16'hA001, 2'b10));
    alu_end = 1'b0;
    tick("jmp_fetch", o_fetch(16'hA001));

    // Reset in the middle of EXEC aborts to IDLE and clears IR.
    ins = 16'h2500; en_ram_out = 1'b1;
    tick("abort_decode", o_zero(16'h2500));
    en_ram_out = 1'b0;
    tick("abort_exec", o_exec(16'h2500, 3'b001, 1'b0));
    rst = 1'b0;
    tick("abort_idle", o_zero(16'h0000));
    rst = 1'b1;
    tick("abort_fetch", o_fetch(16'h0000));

    // Illegal opcode 111.
    ins = 16'hF000; en_ram_out = 1'b1;
    tick("nop_decode", o_zero(16'hF000));
    en_ram_out = 1'b0;
`ifdef CU_ILLEGAL_HALT_EN
    for (int i = 0; i < 3; i++) begin
      en_ram_out = 1'b1; alu_end = 1'b1; ins = 16'h0002;
      tick("halt_hold", o_zero(16'hF000));
    end
    en_ram_out = 1'b0; alu_end = 1'b0;
    rst = 1'b0;
    tick("halt_reset", o_zero(16'h0000));
    rst = 1'b1;
    tick("halt_fetch", o_fetch(16'h0000));
`else
    tick("nop_pcupd", o_pc(16'hF000, 2'b01));
    tick("nop_fetch", o_fetch(16'hF000));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
